// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and register-address type for the register-file read unit
package rf_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;
  localparam int DEF_AW    = 3;
  typedef logic [DEF_AW-1:0] reg_addr_t;
endpackage

// File: rtl/rf_read_unit_if.sv
// rf_read_unit_if: writeback, issue/read request and read-response signals of the read unit
// master drives wr_*/rd_req/rd_addr_*/dst_*; slave drives stall/rd_valid/rd_data_*
interface rf_read_unit_if
  import rf_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic             wr_en;
  reg_addr_t        wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  reg_addr_t        rd_addr_a;
  reg_addr_t        rd_addr_b;
  logic             dst_en;
  reg_addr_t        dst_addr;
  logic             stall;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  modport master (output wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b, dst_en, dst_addr,
                  input stall, rd_valid, rd_data_a, rd_data_b);
  modport slave  (input wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b, dst_en, dst_addr,
                  output stall, rd_valid, rd_data_a, rd_data_b);
endinterface

// File: rtl/rf_word.sv
// rf_word: one WIDTH-bit storage word with write enable and async active-low reset
// ports: clk, rst (active-low), i_we write enable, i_d write data, o_q stored value
module rf_word #(parameter int WIDTH = rf_pkg::DEF_WIDTH) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_q <= '0;
    else if (i_we) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/rf_read_unit.sv
// rf_read_unit: register file with busy scoreboard, writeback bypass and registered two-port read
// ports: clk, rst (async active-low), bus (slave side of rf_read_unit_if)
module rf_read_unit
  import rf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  rf_read_unit_if.slave bus
);
  logic [WIDTH-1:0] w_q [NREGS];
  logic [NREGS-1:0] w_hit, w_set, r_busy;
  logic             w_blk_a, w_blk_b, w_stall, w_acc, r_valid;
  logic [WIDTH-1:0] w_rd_a, w_rd_b, r_a, r_b;
  assign w_q[0] = '0;
  for (genvar g = 1; g < NREGS; g++) begin : g_word
    rf_word #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .rst (rst),
      .i_we(bus.wr_en && bus.wr_addr == AW'(g)),
      .i_d (bus.wr_data),
      .o_q (w_q[g])
    );
  end
  // register 0 is masked out of both vectors so it is never busy and never bypassed
  assign w_hit   = bus.wr_en ? (NREGS'(1) << bus.wr_addr) & ~NREGS'(1) : '0;
  assign w_blk_a = r_busy[bus.rd_addr_a] && !w_hit[bus.rd_addr_a];
  assign w_blk_b = r_busy[bus.rd_addr_b] && !w_hit[bus.rd_addr_b];
  assign w_stall = bus.rd_req && (w_blk_a || w_blk_b);
  assign w_acc   = bus.rd_req && !w_stall;
  assign w_set   = (w_acc && bus.dst_en) ? (NREGS'(1) << bus.dst_addr) & ~NREGS'(1) : '0;
  assign w_rd_a  = w_hit[bus.rd_addr_a] ? bus.wr_data : w_q[bus.rd_addr_a];
  assign w_rd_b  = w_hit[bus.rd_addr_b] ? bus.wr_data : w_q[bus.rd_addr_b];
  // set after clear: a same-cycle issue to the written register is younger and stays pending
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_busy  <= '0;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_busy  <= (r_busy & ~w_hit) | w_set;
      r_valid <= w_acc;
      if (w_acc) begin
        r_a <= w_rd_a;
        r_b <= w_rd_b;
      end
    end
  assign bus.stall     = w_stall;
  assign bus.rd_valid  = r_valid;
  assign bus.rd_data_a = r_a;
  assign bus.rd_data_b = r_b;
endmodule

// File: tb/tb_rf_read_unit.sv
// tb_rf_read_unit: directed scoreboard bench for rf_read_unit
module tb_rf_read_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] q_exp [$];
  logic [15:0] last_a = '0, last_b = '0;
  always #5 clk = ~clk;
  rf_read_unit_if #(.WIDTH(16)) bus ();
  rf_read_unit u_dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rq, input int a, input int b, input logic de, input int d,
                       input logic we, input int wa, input logic [15:0] wd);
    bus.rd_req    = rq;
    bus.rd_addr_a = 3'(a);
    bus.rd_addr_b = 3'(b);
    bus.dst_en    = de;
    bus.dst_addr  = 3'(d);
    bus.wr_en     = we;
    bus.wr_addr   = 3'(wa);
    bus.wr_data   = wd;
  endtask

  task automatic step(input string tag, input logic rq, input int a, input int b, input logic de,
                      input int d, input logic we, input int wa, input logic [15:0] wd,
                      input logic es, input logic [15:0] ea, input logic [15:0] eb);
    logic [31:0] e;
    @(negedge clk);
    drive(rq, a, b, de, d, we, wa, wd);
    #1;
    chk({tag, "_stall"}, 32'(bus.stall), 32'(es));
    if (rq && !es) q_exp.push_back({ea, eb});
    @(posedge clk);
    #1;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
      chk({tag, "_a"}, 32'(bus.rd_data_a), 32'(e[31:16]));
      chk({tag, "_b"}, 32'(bus.rd_data_b), 32'(e[15:0]));
      last_a = e[31:16];
      last_b = e[15:0];
    end else begin
      chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd0);
      chk({tag, "_hold_a"}, 32'(bus.rd_data_a), 32'(last_a));
      chk({tag, "_hold_b"}, 32'(bus.rd_data_b), 32'(last_b));
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    #3;
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_a", 32'(bus.rd_data_a), 32'd0);
    chk("rst_b", 32'(bus.rd_data_b), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step("first",   1, 3, 5, 0, 0, 0, 0, 16'h0,    0, 16'h0,    16'h0);
    step("idle",    0, 0, 0, 0, 0, 0, 0, 16'h0,    0, 16'h0,    16'h0);
    step("wr_r2",   0, 0, 0, 0, 0, 1, 2, 16'h1234, 0, 16'h0,    16'h0);
    step("rd_r2",   1, 2, 0, 0, 0, 0, 0, 16'h0,    0, 16'h1234, 16'h0);
    step("bypass",  1, 7, 2, 0, 0, 1, 7, 16'h7777, 0, 16'h7777, 16'h1234);
    step("wr_r1",   0, 0, 0, 0, 0, 1, 1, 16'h1111, 0, 16'h0,    16'h0);
    step("wr_r3",   0, 0, 0, 0, 0, 1, 3, 16'h3333, 0, 16'h0,    16'h0);
    step("iss_d4",  1, 1, 0, 1, 4, 0, 0, 16'h0,    0, 16'h1111, 16'h0);
    step("stl4_0",  1, 4, 0, 1, 5, 0, 0, 16'h0,    1, 16'h0,    16'h0);
    step("stl4_1",  1, 4, 0, 1, 5, 0, 0, 16'h0,    1, 16'h0,    16'h0);
    step("stl4_2",  1, 4, 0, 1, 5, 0, 0, 16'h0,    1, 16'h0,    16'h0);
    step("wb_r4",   1, 4, 0, 0, 0, 1, 4, 16'hBEEF, 0, 16'hBEEF, 16'h0);
    step("r5_free", 1, 5, 4, 0, 0, 0, 0, 16'h0,    0, 16'h0,    16'hBEEF);
    step("setclr6", 1, 0, 0, 1, 6, 1, 6, 16'h6666, 0, 16'h0,    16'h0);
    step("stl6",    1, 6, 0, 0, 0, 0, 0, 16'h0,    1, 16'h0,    16'h0);
    step("wb_r6",   1, 6, 0, 0, 0, 1, 6, 16'h0606, 0, 16'h0606, 16'h0);
    step("self3",   1, 3, 3, 1, 3, 0, 0, 16'h0,    0, 16'h3333, 16'h3333);
    step("stl3",    1, 0, 3, 0, 0, 0, 0, 16'h0,    1, 16'h0,    16'h0);
    step("wb_r3",   0, 0, 0, 0, 0, 1, 3, 16'h4444, 0, 16'h0,    16'h0);
    step("rd_r3",   1, 3, 0, 0, 0, 0, 0, 16'h0,    0, 16'h4444, 16'h0);
    step("r0_wr",   1, 0, 0, 1, 0, 1, 0, 16'hFFFF, 0, 16'h0,    16'h0);
    step("r0_rd",   1, 0, 2, 0, 0, 0, 0, 16'h0,    0, 16'h0,    16'h1234);
    step("iss_d1",  1, 0, 0, 1, 1, 0, 0, 16'h0,    0, 16'h0,    16'h0);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0, 16'h0);
    #1;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("mid_rst_a", 32'(bus.rd_data_a), 32'd0);
    chk("mid_rst_b", 32'(bus.rd_data_b), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    q_exp.delete();
    last_a = '0;
    last_b = '0;
    @(negedge clk);
    rst = 1'b1;
    step("post_r1", 1, 1, 2, 0, 0, 0, 0, 16'h0,    0, 16'h0,    16'h0);
    step("post_r4", 1, 4, 7, 0, 0, 0, 0, 16'h0,    0, 16'h0,    16'h0);
    step("post_idle", 0, 0, 0, 0, 0, 0, 0, 16'h0,  0, 16'h0,    16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
